morse_char_tx: RTL and testbench
================================

// Module: morse_char_tx
// PURPOSE
//  Streaming Morse keyer. Accepts ASCII characters over a valid/ready handshake and
//  generates the on/off key waveform with standard ITU timing (dot 1u, dash 3u,
//  1u intra-char, 3u letter gap, 7u word gap). Replaces hard-coded blink patterns:
//  the upstream feeder (UART/ROM sequencer) pushes text; key_out drives led[] in top.
// PARAMETERS
//  UNIT_CYCLES  2097152  clk cycles per Morse time unit (>=2)
//  DASH_UNITS   3        dash length in units (1..7)
//  LETTER_GAP   3        off units after a character's last element (1..7)
//  WORD_GAP     7        total off units between words, incl. letter gap (>LETTER_GAP)
//  LED_W        8        width of led output
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous, active-high reset
//  char_data   in   8      ASCII character
//  char_valid  in   1      char_data valid
//  char_ready  out  1      block can accept a character
//  key_out     out  1      Morse key: 1 = tone/LED on
//  led         out  LED_W  all bits = key_out
//  busy        out  1      high whenever not in IDLE
//  err         out  1      1-cycle pulse: unsupported character dropped
// BEHAVIOUR
//  - Reset (rst sampled high at an edge): state IDLE, key_out=0, led=0, busy=0, err=0,
//    char_ready=1, counters 0. Mid-character reset aborts at once; no partial gap.
//  - Handshake: char_ready=1 only in IDLE; accept on edge with valid&&ready (edge N).
//    char_data latched on accept; ignored otherwise. No buffering, one char in flight.
//  - FSM: IDLE -> LOOKUP -> MARK <-> ELEM_GAP -> CHAR_GAP -> IDLE; LOOKUP -> IDLE on err.
//    LOOKUP (one cycle, after N): registered LUT gives len (1..5), pattern (bit i=1 dash,
//    element 0 = bit 0, LSB first), kind {SYMBOL, SPACE, INVALID}.
//  - SYMBOL: MARK from edge N+2, key_out=1 for 1u (dot) or DASH_UNITS u (dash); then
//    ELEM_GAP key_out=0 for 1u if more elements remain; after last element, CHAR_GAP
//    key_out=0 for LETTER_GAP u, then IDLE (char_ready=1).
//  - SPACE (0x20): CHAR_GAP with key_out=0 for WORD_GAP-LETTER_GAP u, then IDLE.
//  - INVALID: err=1 for exactly the cycle after LOOKUP (N+2), state IDLE in that cycle.
//  - Supported: A-Z, a-z (folded to upper), 0-9, space. All else INVALID.
//  - Timing: cycle counter width $clog2(UNIT_CYCLES), cleared on every state entry, so
//    each phase lasts exactly units*UNIT_CYCLES cycles; unit counter 3 bits.
//  - key_out is a registered output; no glitches; led = {LED_W{key_out}}.
//  - Back-to-back chars: valid held high -> next accept on first IDLE cycle; next
//    char's MARK begins 2 cycles after that accept (no extra gap beyond LETTER_GAP).
//  - busy = (state != IDLE); char_ready = ~busy.
// STRUCTURE
//  - morse_pkg: state enum, kind enum, MAX_ELEMS=5, ASCII constants (SPACE, 'a','z').
//  - Sub-module morse_lut: combinational char -> {kind, len[2:0], pattern[4:0]};
//    morse_char_tx registers its output in LOOKUP. Rest (FSM + counters) in top module.
// TESTING  (UNIT_CYCLES=4, defaults otherwise; N = accept edge)
//  - Reset: rst=1 2 cycles -> key_out=0, busy=0, char_ready=1, err=0.
//  - 'E' (0x45) -> key_out=1 for cycles N+2..N+5, 0 for 12 cycles, char_ready=1 at N+18.
//  - 'a' (0x61) -> high 4, low 4, high 12, low 12; identical to 'A'; ready at N+34.
//  - "0" then ' ' held valid -> 5 dashes (12 on, 4 off x4, last then 12 off), then
//    space keeps key_out=0 for 16 more cycles; second accept on first IDLE cycle.
//  - '#' (0x23) -> err=1 at N+2 only, key_out never high, char_ready=1 at N+2.
//  - rst asserted during dash of 'T' -> next cycle key_out=0, IDLE; new 'E' then
//    produces exact 'E' waveform.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse character keyer.
package morse_pkg;

    localparam int unsigned MAX_ELEMS = 5;
    localparam int unsigned ELEM_W    = $clog2(MAX_ELEMS);

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MARK,
        ST_ELEM_GAP,
        ST_CHAR_GAP
    } state_t;

    typedef enum logic [1:0] {
        K_SYMBOL,
        K_SPACE,
        K_INVALID
    } kind_t;

    // Element i of a character is a dash when pattern[i] is set; element 0 is sent first.
    typedef struct packed {
        kind_t                  kind;
        logic [ELEM_W-1:0]      len;
        logic [MAX_ELEMS-1:0]   pattern;
    } lut_t;

    function automatic lut_t make_sym(input logic [ELEM_W-1:0] len,
                                      input logic [MAX_ELEMS-1:0] pattern);
        lut_t r;
        r.kind    = K_SYMBOL;
        r.len     = len;
        r.pattern = pattern;
        return r;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII to Morse element table; lower-case letters fold to upper case.
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0] ch_i,
    output lut_t       code_o
);

    logic [7:0] uc;

    always_comb begin
        uc = ch_i;
        if (ch_i >= ASCII_LC_A && ch_i <= ASCII_LC_Z) begin
            uc = ch_i - CASE_OFFSET;
        end

        code_o.kind    = K_INVALID;
        code_o.len     = '0;
        code_o.pattern = '0;

        case (uc)
            ASCII_SPACE: code_o.kind = K_SPACE;
            8'h41: code_o = make_sym(3'd2, 5'b00010); // A .-
            8'h42: code_o = make_sym(3'd4, 5'b00001); // B -...
            8'h43: code_o = make_sym(3'd4, 5'b00101); // C -.-.
            8'h44: code_o = make_sym(3'd3, 5'b00001); // D -..
            8'h45: code_o = make_sym(3'd1, 5'b00000); // E .
            8'h46: code_o = make_sym(3'd4, 5'b00100); // F ..-.
            8'h47: code_o = make_sym(3'd3, 5'b00011); // G --.
            8'h48: code_o = make_sym(3'd4, 5'b00000); // H ....
            8'h49: code_o = make_sym(3'd2, 5'b00000); // I ..
            8'h4A: code_o = make_sym(3'd4, 5'b01110); // J .---
            8'h4B: code_o = make_sym(3'd3, 5'b00101); // K -.-
            8'h4C: code_o = make_sym(3'd4, 5'b00010); // L .-..
            8'h4D: code_o = make_sym(3'd2, 5'b00011); // M --
            8'h4E: code_o = make_sym(3'd2, 5'b00001); // N -.
            8'h4F: code_o = make_sym(3'd3, 5'b00111); // O ---
            8'h50: code_o = make_sym(3'd4, 5'b00110); // P .--.
            8'h51: code_o = make_sym(3'd4, 5'b01011); // Q --.-
            8'h52: code_o = make_sym(3'd3, 5'b00010); // R .-.
            8'h53: code_o = make_sym(3'd3, 5'b00000); // S ...
            8'h54: code_o = make_sym(3'd1, 5'b00001); // T -
            8'h55: code_o = make_sym(3'd3, 5'b00100); // U ..-
            8'h56: code_o = make_sym(3'd4, 5'b01000); // V ...-
            8'h57: code_o = make_sym(3'd3, 5'b00110); // W .--
            8'h58: code_o = make_sym(3'd4, 5'b01001); // X -..-
            8'h59: code_o = make_sym(3'd4, 5'b01101); // Y -.--
            8'h5A: code_o = make_sym(3'd4, 5'b00011); // Z --..
            8'h30: code_o = make_sym(3'd5, 5'b11111); // 0 -----
            8'h31: code_o = make_sym(3'd5, 5'b11110); // 1 .----
            8'h32: code_o = make_sym(3'd5, 5'b11100); // 2 ..---
            8'h33: code_o = make_sym(3'd5, 5'b11000); // 3 ...--
            8'h34: code_o = make_sym(3'd5, 5'b10000); // 4 ....-
            8'h35: code_o = make_sym(3'd5, 5'b00000); // 5 .....
            8'h36: code_o = make_sym(3'd5, 5'b00001); // 6 -....
            8'h37: code_o = make_sym(3'd5, 5'b00011); // 7 --...
            8'h38: code_o = make_sym(3'd5, 5'b00111); // 8 ---..
            8'h39: code_o = make_sym(3'd5, 5'b01111); // 9 ----.
            default: ;
        endcase
    end

endmodule

// File: rtl/morse_char_tx.sv
// Streaming Morse keyer: one ASCII character per valid/ready handshake, keyed out with
// ITU unit timing on key_out and mirrored onto every led bit.
module morse_char_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 2097152,
    parameter int unsigned DASH_UNITS  = 3,
    parameter int unsigned LETTER_GAP  = 3,
    parameter int unsigned WORD_GAP    = 7,
    parameter int unsigned LED_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       char_data,
    input  logic             char_valid,
    output logic             char_ready,
    output logic             key_out,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CYC_W  = $clog2(UNIT_CYCLES);
    localparam int unsigned UNIT_W = 3;

    state_t              state_q, state_d;
    logic [7:0]          char_q, char_d;
    lut_t                lut_q, lut_d, lut_c;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [UNIT_W-1:0]   unit_q, unit_d;
    logic                key_q, key_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic                unit_last;
    logic                phase_done;
    int unsigned         phase_units;

    morse_lut u_lut (
        .ch_i   (char_q),
        .code_o (lut_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            char_q  <= '0;
            lut_q   <= '{kind: K_INVALID, len: '0, pattern: '0};
            elem_q  <= '0;
            cyc_q   <= '0;
            unit_q  <= '0;
            key_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            lut_q   <= lut_d;
            elem_q  <= elem_d;
            cyc_q   <= cyc_d;
            unit_q  <= unit_d;
            key_q   <= key_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Length in units of the phase currently being timed.
    always_comb begin
        phase_units = 1;
        case (state_q)
            ST_MARK:     phase_units = lut_q.pattern[elem_q] ? DASH_UNITS : 1;
            ST_CHAR_GAP: phase_units = (lut_q.kind == K_SPACE) ? (WORD_GAP - LETTER_GAP)
                                                                : LETTER_GAP;
            default:     phase_units = 1;
        endcase
    end

    assign unit_last  = (cyc_q == CYC_W'(UNIT_CYCLES - 1));
    assign phase_done = unit_last && (unit_q == UNIT_W'(phase_units - 1));

    always_comb begin
        state_d = state_q;
        char_d  = char_q;
        lut_d   = lut_q;
        elem_d  = elem_q;
        cyc_d   = cyc_q + CYC_W'(1);
        unit_d  = unit_q;
        err_d   = 1'b0;

        if (unit_last) begin
            cyc_d  = '0;
            unit_d = unit_q + UNIT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (char_valid) begin
                    char_d  = char_data;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                lut_d  = lut_c;
                elem_d = '0;
                case (lut_c.kind)
                    K_INVALID: begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                    K_SPACE:   state_d = ST_CHAR_GAP;
                    default:   state_d = ST_MARK;
                endcase
            end
            ST_MARK: begin
                if (phase_done) begin
                    state_d = (elem_q == lut_q.len - ELEM_W'(1)) ? ST_CHAR_GAP : ST_ELEM_GAP;
                end
            end
            ST_ELEM_GAP: begin
                if (phase_done) begin
                    state_d = ST_MARK;
                    elem_d  = elem_q + ELEM_W'(1);
                end
            end
            ST_CHAR_GAP: begin
                if (phase_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every phase is timed from zero on entry; idle keeps the counters parked.
        if (state_d != state_q || state_q == ST_IDLE) begin
            cyc_d  = '0;
            unit_d = '0;
        end

        key_d  = (state_d == ST_MARK);
        busy_d = (state_d != ST_IDLE);
    end

    assign key_out    = key_q;
    assign led        = {LED_W{key_q}};
    assign busy       = busy_q;
    assign char_ready = ~busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_morse_char_tx.sv
// Self-checking bench for morse_char_tx: directed and random characters against a
// dot/dash string model of ITU Morse timing.
module tb_morse_char_tx;

    localparam int unsigned U     = 4;
    localparam int unsigned DASH  = 3;
    localparam int unsigned LG    = 3;
    localparam int unsigned WG    = 7;
    localparam int unsigned LW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    char_data;
    logic          char_valid;
    logic          char_ready;
    logic          key_out;
    logic [LW-1:0] led;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    bit exp_key[$];
    int exp_kind;        // 0 symbol, 1 space, 2 invalid

    string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                            ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                            "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits [10]  = '{"-----", ".----", "..---", "...--", "....-",
                            ".....", "-....", "--...", "---..", "----."};

    morse_char_tx #(
        .UNIT_CYCLES (U),
        .DASH_UNITS  (DASH),
        .LETTER_GAP  (LG),
        .WORD_GAP    (WG),
        .LED_W       (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .led        (led),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected key waveform, one entry per cycle after the lookup cycle.
    function automatic void build_expected(input logic [7:0] c);
        logic [7:0] uc;
        string      code;
        exp_key.delete();
        uc = c;
        if (c >= 8'h61 && c <= 8'h7A) uc = c - 8'h20;
        code = "";
        exp_kind = 2;
        if (uc >= 8'h41 && uc <= 8'h5A) begin
            code = letters[uc - 8'h41];
            exp_kind = 0;
        end else if (uc >= 8'h30 && uc <= 8'h39) begin
            code = digits[uc - 8'h30];
            exp_kind = 0;
        end else if (uc == 8'h20) begin
            exp_kind = 1;
        end
        if (exp_kind == 0) begin
            for (int i = 0; i < code.len(); i++) begin
                int on_len;
                on_len = (code[i] == "-") ? DASH * U : U;
                for (int k = 0; k < on_len; k++) exp_key.push_back(1'b1);
                if (i < code.len() - 1)
                    for (int k = 0; k < U; k++) exp_key.push_back(1'b0);
            end
            for (int k = 0; k < LG * U; k++) exp_key.push_back(1'b0);
        end else if (exp_kind == 1) begin
            for (int k = 0; k < (WG - LG) * U; k++) exp_key.push_back(1'b0);
        end
    endfunction

    // Called at a negedge. Offers c, checks the whole response and returns at the first
    // idle cycle. With hold set, valid stays high carrying nxt for the next call.
    task automatic send(input logic [7:0] c, input bit hold, input logic [7:0] nxt,
                        input bit expect_now);
        int wait_n;
        wait_n = 0;
        char_data  = c;
        char_valid = 1'b1;
        while (char_ready !== 1'b1 && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        chk("accept_ready", 32'(char_ready), 32'd1);
        if (expect_now) chk("b2b_first_idle_wait", 32'(wait_n), 32'd0);
        @(posedge clk);
        #1;
        if (hold) char_data = nxt;
        else begin
            char_valid = 1'b0;
            char_data  = 8'($urandom);
        end
        build_expected(c);
        @(negedge clk);
        chk("lookup_busy", 32'(busy), 32'd1);
        chk("lookup_ready", 32'(char_ready), 32'd0);
        chk("lookup_key", 32'(key_out), 32'd0);
        if (exp_kind == 2) begin
            @(negedge clk);
            chk("inv_err", 32'(err), 32'd1);
            chk("inv_ready", 32'(char_ready), 32'd1);
            chk("inv_key", 32'(key_out), 32'd0);
            if (!hold) begin
                @(negedge clk);
                chk("inv_err_single", 32'(err), 32'd0);
            end
            return;
        end
        for (int i = 0; i < exp_key.size(); i++) begin
            @(negedge clk);
            chk($sformatf("key[%0d] ch=%0h", i, c), 32'(key_out), 32'(exp_key[i]));
            chk("led", 32'(led), 32'({LW{exp_key[i]}}));
            chk("busy_active", 32'(busy), 32'd1);
            chk("err_quiet", 32'(err), 32'd0);
        end
        @(negedge clk);
        chk("done_ready", 32'(char_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_key", 32'(key_out), 32'd0);
    endtask

    logic [7:0] pool [16] = '{8'h41, 8'h5A, 8'h61, 8'h7A, 8'h30, 8'h39, 8'h20, 8'h23,
                              8'h7E, 8'h40, 8'h4D, 8'h71, 8'h35, 8'h21, 8'h51, 8'h5B};
    logic [7:0] rnd [20];
    bit         rhold [20];

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key", 32'(key_out), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(char_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(char_ready), 32'd1);

        send(8'h45, 1'b0, 8'h00, 1'b0);          // E
        send(8'h61, 1'b0, 8'h00, 1'b0);          // a
        send(8'h41, 1'b0, 8'h00, 1'b0);          // A
        send(8'h30, 1'b1, 8'h20, 1'b0);          // 0 then space held valid
        send(8'h20, 1'b0, 8'h00, 1'b1);
        send(8'h23, 1'b0, 8'h00, 1'b0);          // #

        // Reset in the middle of the dash of 'T'.
        char_data  = 8'h54;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("t_dash_on", 32'(key_out), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_key", 32'(key_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(char_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h45, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rnd[i]   = pool[$urandom_range(15, 0)];
            rhold[i] = 1'($urandom_range(1, 0));
        end
        rhold[19] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(rnd[i], rhold[i], (i < 19) ? rnd[i+1] : 8'h00, (i > 0) ? rhold[i-1] : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
